// File: rtl/uart_txd.sv
// rtl/uart_txd.sv - 8-bit UART transmitter; optional even parity bit via UART_TXD_PARITY_EN
module uart_txd #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int MSB_FIRST       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       txd,
    output logic       done_o
);
    localparam int LENGTH_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W       = $clog2(LENGTH_BAUD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LENGTH_BAUD - 1);

`ifdef UART_TXD_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift, shift_next;
    logic             txd_next, done_next, boundary, accept;
`ifdef UART_TXD_PARITY_EN
    logic             parity, parity_next;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        done_next  = 1'b0;
        boundary   = (cnt == CNT_MAX);
        accept     = 1'b0;
        if (state != IDLE) begin
            cnt_next = boundary ? '0 : cnt + CNT_W'(1);
        end
        case (state)
            IDLE: begin
                if (valid_i && ready_o) begin
                    accept     = 1'b1;
                    shift_next = data_i;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (boundary) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (boundary) begin
                    shift_next = (MSB_FIRST != 0) ? {shift[6:0], 1'b1} : {1'b1, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TXD_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TXD_PARITY_EN
            PARITY: begin
                if (boundary) state_next = STOP;
            end
`endif
            STOP: begin
                if (boundary) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_TXD_PARITY_EN
    assign parity_next = accept ? ^data_i : parity;
`endif

    // txd is registered from the next state so each line bit starts exactly on its edge.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = (MSB_FIRST != 0) ? shift_next[7] : shift_next[0];
`ifdef UART_TXD_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'hFF;
            txd     <= 1'b1;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            txd     <= txd_next;
            ready_o <= (state_next == IDLE);
            done_o  <= done_next;
        end
    end

`ifdef UART_TXD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity <= 1'b0;
        else     parity <= parity_next;
    end
`endif
endmodule

// File: tb/tb_uart_txd.sv
// tb/tb_uart_txd.sv - randomized scoreboard bench for uart_txd (8N1, or 8E1 with UART_TXD_PARITY_EN)
module tb_uart_txd;
    localparam int CLOCK_FREQUENCY = 16;
    localparam int BAUD_RATE       = 1;
    localparam int MSB_FIRST       = 0;
    localparam int L               = CLOCK_FREQUENCY / BAUD_RATE;
`ifdef UART_TXD_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * L;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o, txd, done_o;

    frame_t exp_q[$];
    logic   exp_bits[$];
    int     total = 0, passed = 0;
    bit     in_frame = 1'b0;
    int     idx = 0, idle_run = 0, fnum = 0;

    uart_txd #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
        .BAUD_RATE(BAUD_RATE),
        .MSB_FIRST(MSB_FIRST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .txd(txd),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Expected line: start, data bits in wire order, optional even parity, stop.
    task automatic build_bits(input logic [7:0] d);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(MSB_FIRST != 0 ? d[7 - i] : d[i]);
`ifdef UART_TXD_PARITY_EN
        exp_bits.push_back(^d);
`endif
        exp_bits.push_back(1'b1);
    endtask

    initial begin : monitor
        frame_t f;
        bit     bit_bad, ctl_bad;
        bit_bad = 1'b0;
        ctl_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                idle_run = 0;
            end else begin
                if (!in_frame) begin
                    if (done_o) check("spurious_done", 1'b0, 1, 0);
                    if (txd) idle_run++;
                    else if (exp_q.size() == 0) check("unexpected_frame", 1'b0, 0, 1);
                    else begin
                        f = exp_q.pop_front();
                        build_bits(f.data);
                        if (f.gap >= 0) check("line_gap", idle_run == f.gap, idle_run, f.gap);
                        fnum++;
                        in_frame = 1'b1;
                        idx      = 0;
                        bit_bad  = 1'b0;
                        ctl_bad  = 1'b0;
                    end
                end
                if (in_frame) begin
                    if (idx < FL) begin
                        if (txd !== exp_bits[idx / L]) bit_bad = 1'b1;
                        if (done_o !== 1'b0 || ready_o !== 1'b0) ctl_bad = 1'b1;
                        if (idx % L == L - 1) begin
                            check($sformatf("frame%0d_bit%0d", fnum, idx / L), !bit_bad,
                                  {31'd0, txd}, {31'd0, exp_bits[idx / L]});
                            bit_bad = 1'b0;
                        end
                        idx++;
                    end else begin
                        check($sformatf("frame%0d_end", fnum),
                              done_o === 1'b1 && ready_o === 1'b1 && txd === 1'b1,
                              {29'd0, done_o, ready_o, txd}, 32'h7);
                        check($sformatf("frame%0d_busy_ctl", fnum), !ctl_bad, {31'd0, ctl_bad}, 0);
                        in_frame = 1'b0;
                        idle_run = 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int gap);
        int n;
        n       = 0;
        data_i  = d;
        valid_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 4 * FL);
        check("accept_wait", ready_o === 1'b1, {31'd0, ready_o}, 1);
        if (ready_o) begin
            frame_t f;
            f.data = d;
            f.gap  = gap;
            exp_q.push_back(f);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 4 * FL) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", exp_q.size() == 0 && !in_frame, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int bad;
        int mode;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_txd", txd === 1'b1, {31'd0, txd}, 1);
        check("reset_ready", ready_o === 1'b1, {31'd0, ready_o}, 1);
        check("reset_done", done_o === 1'b0, {31'd0, done_o}, 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || ready_o !== 1'b1 || done_o !== 1'b0) bad++;
        end
        check("quiet_idle", bad == 0, bad, 0);
        @(posedge clk);
        #1;

        send(8'hA5, -1);
        valid_i = 1'b0;
        wait_idle();

        send(8'h00, -1);
        send(8'hFF, 1);
        valid_i = 1'b0;
        wait_idle();

        send(8'h96, -1);
        valid_i = 1'b0;
        repeat (3 * L + 5) @(posedge clk);
        #1;
        data_i  = 8'h3C;
        valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        wait_idle();

        send(8'h5A, -1);
        valid_i = 1'b0;
        repeat (5 * L + 4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_txd", txd === 1'b1, {31'd0, txd}, 1);
        check("abort_ready", ready_o === 1'b1, {31'd0, ready_o}, 1);
        check("abort_done", done_o === 1'b0, {31'd0, done_o}, 0);
        repeat (2 * FL) @(posedge clk);
        #1;
        send(8'h81, -1);
        valid_i = 1'b0;
        wait_idle();

        send(8'h07, -1);
        valid_i = 1'b0;
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 2);
            send(8'($urandom), -1);
            if (mode == 1) send(8'($urandom), 1);
            valid_i = 1'b0;
            if (mode == 2) begin
                repeat ($urandom_range(1, FL - 20)) @(posedge clk);
                #1;
                data_i  = 8'($urandom);
                valid_i = 1'b1;
                @(posedge clk);
                #1 valid_i = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
